tt_vec_mul_wb: RTL
==================

# tt_vec_mul_wb

Result stage directly downstream of the vector multiplier datapath. It consumes the per-lane 129-bit products one cycle after multiply enable, selects the low or high SEW half per element, and optionally accumulates against an addend (vmacc/vnmsac). It packs elements into a VLEN-bit result with byte enables and presents it to writeback through a valid/ready interface. A two-entry output buffer (main register plus skid) provides backpressure.

## Interface
- VLEN, 256: vector register width in bits; multiple of 64.
- TAGW, 8: width of the opaque tag carried alongside each result.

- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_vld_1a  in  1  product beat valid.
- o_rdy_1a  out  1  stage can accept a beat; registered.
- i_sum_1a  in  [VLEN/8-1:0][128:0]  per-lane full-width products, already sign/zero-extended.
- i_sew_1a  in  2  element width: 0=8, 1=16, 2=32, 3=64 bits.
- i_hi_1a  in  1  select product bits [2*SEW-1:SEW] (vmulh*); otherwise [SEW-1:0].
- i_acc_op_1a  in  2  0=none, 1=add (addend+prod), 2=sub (addend−prod), 3=reserved.
- i_addend_1a  in  VLEN  old vd, element k at [k*SEW +: SEW].
- i_tag_1a  in  TAGW  passthrough tag.
- o_vld_2a  out  1  result valid.
- i_rdy_2a  in  1  writeback accepts result.
- o_res_2a  out  VLEN  packed result.
- o_be_2a  out  VLEN/8  byte enables of valid result bytes.
- o_tag_2a  out  TAGW  tag of o_res_2a.
- o_err_2a  out  1  beat carried reserved acc_op.

## Operation
- Lane map by SEW: 8 → lanes VLEN/16..VLEN/8-1 (VLEN/16 elems); 16 → VLEN/32..VLEN/16-1; 32 → VLEN/64..VLEN/32-1; 64 → 0..VLEN/64-1. Element k = lane base+k.
- Per element: p = i_hi_1a ? sum[2*SEW-1:SEW] : sum[SEW-1:0].
- Accumulate applies only when i_hi_1a=0. If i_hi_1a=1, acc_op is ignored.
- add: r = addend_k + p. sub: r = addend_k − p. Both are mod 2^SEW, with no saturation.
- reserved acc_op: r = p, o_err_2a=1 for that beat.
- Packing: r_k goes to o_res_2a[k*SEW +: SEW]. Bytes beyond element count are 0, and their o_be_2a bits are 0. Valid bytes: VLEN/16 bytes for SEW 8/16/32, VLEN/8 bytes for SEW 64.
- Buffer: main register M (drives outputs) and skid register S, transfers in FIFO order.
  - Accept when i_vld_1a && o_rdy_1a.
  - Accepted beat loads M if M is empty or M is draining this cycle with S empty; otherwise it loads S.
  - When M drains with S full, S moves to M.
  - o_rdy_1a = !S_full of next state, registered.
- Simultaneous accept and drain with M full and S empty: new beat loads M, no bubble.

## Timing
- Latency: beat accepted at edge N appears on o_vld_2a/o_res_2a during cycle N+1.
- Throughput: 1 beat/cycle while i_rdy_2a=1.
- o_rdy_1a falls the cycle after S fills. It rises the cycle after S empties.
- Outputs are stable while o_vld_2a && !i_rdy_2a.
- Reset, asynchronous at any time including mid-flight:
  - o_vld_2a=0, o_rdy_1a=1, o_res_2a=0, o_be_2a=0, o_tag_2a=0, o_err_2a=0, M/S empty.
  - Buffered beats are discarded.

## Structure
- Package tt_vec_mul_pkg holds:
  - sew_e enum.
  - acc_op_e enum.
  - Functions lane_base(sew,VLEN) and lane_cnt(sew,VLEN).
  - Constant PROD_W=129.
- Sub-module tt_vec_mul_pack: purely combinational select/accumulate/pack producing res, be and err from 1a inputs.
- Top level holds M/S registers and handshake.

## Test plan
- VLEN=256, SEW8, hi=0, acc none; lane 16 sum = −15 sign-extended → o_res_2a[7:0]=0xF1, o_be_2a=0x0000FFFF, one cycle later.
- SEW8, hi=1, same sum → byte0=0xFF. acc_op=1 with hi=1 → still 0xFF, o_err_2a=0.
- SEW32, acc add: lane 4 sum=0x2_0000_0005, addend[31:0]=0x10 → 0x15. acc sub with addend 0x3, prod 0x5 → 0xFFFFFFFE.
- SEW64, acc_op=3: lane 0 sum=0x7 → o_res_2a[63:0]=7, o_be_2a all ones, o_err_2a=1.
- Backpressure: i_rdy_2a=0, present beats A,B,C back-to-back → A,B accepted, o_rdy_1a low from cycle after B, C held. Raise i_rdy_2a → A,B,C emerge in order, no duplicates.
- Reset asserted while M and S are full → all outputs at reset values immediately. After release, o_rdy_1a=1 and the next beat emerges with 1-cycle latency.

Source files
------------

// File: rtl/tt_vec_mul_pkg.sv
// Shared types and lane-mapping helpers for the vector multiplier result stage.
package tt_vec_mul_pkg;

  localparam int PROD_W = 129;

  typedef enum logic [1:0] {
    SEW8  = 2'd0,
    SEW16 = 2'd1,
    SEW32 = 2'd2,
    SEW64 = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2,
    ACC_RSVD = 2'd3
  } acc_op_e;

  function automatic int lane_base(input sew_e sew, input int vlen);
    case (sew)
      SEW8:    return vlen / 16;
      SEW16:   return vlen / 32;
      SEW32:   return vlen / 64;
      SEW64:   return 0;
      default: return 0;
    endcase
  endfunction

  function automatic int lane_cnt(input sew_e sew, input int vlen);
    case (sew)
      SEW8:    return vlen / 16;
      SEW16:   return vlen / 32;
      SEW32:   return vlen / 64;
      SEW64:   return vlen / 64;
      default: return 0;
    endcase
  endfunction

  // Callers truncate the 64-bit result to SEW, which gives the mod 2^SEW wrap.
  function automatic logic [63:0] acc_elem(input logic [63:0] prod, input logic [63:0] addend,
                                           input logic hi, input acc_op_e op);
    if (hi) begin
      return prod;
    end else begin
      case (op)
        ACC_ADD: return addend + prod;
        ACC_SUB: return addend - prod;
        default: return prod;
      endcase
    end
  endfunction

endpackage

// File: rtl/tt_vec_mul_pack.sv
// Combinational select / accumulate / pack of per-lane products into a VLEN result.
module tt_vec_mul_pack
  import tt_vec_mul_pkg::*;
#(
  parameter int VLEN = 256
) (
  input  logic [VLEN/8-1:0][PROD_W-1:0] sum_i,
  input  logic [1:0]                    sew_i,
  input  logic                          hi_i,
  input  logic [1:0]                    acc_op_i,
  input  logic [VLEN-1:0]               addend_i,
  output logic [VLEN-1:0]               res_o,
  output logic [VLEN/8-1:0]             be_o,
  output logic                          err_o
);

  acc_op_e     op_s;
  logic [63:0] p_s;
  logic [63:0] a_s;
  logic [63:0] r_s;
  logic        unused_sum_s;

  assign op_s         = acc_op_e'(acc_op_i);
  assign unused_sum_s = ^sum_i;

  always_comb begin
    res_o = '0;
    be_o  = '0;
    p_s   = 64'd0;
    a_s   = 64'd0;
    r_s   = 64'd0;
    err_o = !hi_i && (op_s == ACC_RSVD);
    case (sew_e'(sew_i))
      SEW8: begin
        for (int k = 0; k < lane_cnt(SEW8, VLEN); k++) begin
          p_s = hi_i ? {56'd0, sum_i[lane_base(SEW8, VLEN)+k][15:8]}
                     : {56'd0, sum_i[lane_base(SEW8, VLEN)+k][7:0]};
          a_s = {56'd0, addend_i[k*8 +: 8]};
          r_s = acc_elem(p_s, a_s, hi_i, op_s);
          res_o[k*8 +: 8] = r_s[7:0];
        end
        be_o[VLEN/16-1:0] = '1;
      end
      SEW16: begin
        for (int k = 0; k < lane_cnt(SEW16, VLEN); k++) begin
          p_s = hi_i ? {48'd0, sum_i[lane_base(SEW16, VLEN)+k][31:16]}
                     : {48'd0, sum_i[lane_base(SEW16, VLEN)+k][15:0]};
          a_s = {48'd0, addend_i[k*16 +: 16]};
          r_s = acc_elem(p_s, a_s, hi_i, op_s);
          res_o[k*16 +: 16] = r_s[15:0];
        end
        be_o[VLEN/16-1:0] = '1;
      end
      SEW32: begin
        for (int k = 0; k < lane_cnt(SEW32, VLEN); k++) begin
          p_s = hi_i ? {32'd0, sum_i[lane_base(SEW32, VLEN)+k][63:32]}
                     : {32'd0, sum_i[lane_base(SEW32, VLEN)+k][31:0]};
          a_s = {32'd0, addend_i[k*32 +: 32]};
          r_s = acc_elem(p_s, a_s, hi_i, op_s);
          res_o[k*32 +: 32] = r_s[31:0];
        end
        be_o[VLEN/16-1:0] = '1;
      end
      SEW64: begin
        for (int k = 0; k < lane_cnt(SEW64, VLEN); k++) begin
          p_s = hi_i ? sum_i[lane_base(SEW64, VLEN)+k][127:64]
                     : sum_i[lane_base(SEW64, VLEN)+k][63:0];
          a_s = addend_i[k*64 +: 64];
          r_s = acc_elem(p_s, a_s, hi_i, op_s);
          res_o[k*64 +: 64] = r_s;
        end
        be_o = '1;
      end
      default: begin
        res_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/tt_vec_mul_wb.sv
// Result stage: packs multiplier products and buffers them (main + skid) toward writeback.
module tt_vec_mul_wb
  import tt_vec_mul_pkg::*;
#(
  parameter int VLEN = 256,
  parameter int TAGW = 8
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_vld_1a,
  output logic                          o_rdy_1a,
  input  logic [VLEN/8-1:0][PROD_W-1:0] i_sum_1a,
  input  logic [1:0]                    i_sew_1a,
  input  logic                          i_hi_1a,
  input  logic [1:0]                    i_acc_op_1a,
  input  logic [VLEN-1:0]               i_addend_1a,
  input  logic [TAGW-1:0]               i_tag_1a,
  output logic                          o_vld_2a,
  input  logic                          i_rdy_2a,
  output logic [VLEN-1:0]               o_res_2a,
  output logic [VLEN/8-1:0]             o_be_2a,
  output logic [TAGW-1:0]               o_tag_2a,
  output logic                          o_err_2a
);

  typedef struct packed {
    logic [VLEN-1:0]   res;
    logic [VLEN/8-1:0] be;
    logic [TAGW-1:0]   tag;
    logic              err;
  } beat_t;

  beat_t new_s, m_q, m_d, s_q, s_d;
  logic  m_vld_q, m_vld_d, s_vld_q, s_vld_d, rdy_q, rdy_d;
  logic  acc_s, drain_s;

  tt_vec_mul_pack #(.VLEN(VLEN)) u_pack (
    .sum_i    (i_sum_1a),
    .sew_i    (i_sew_1a),
    .hi_i     (i_hi_1a),
    .acc_op_i (i_acc_op_1a),
    .addend_i (i_addend_1a),
    .res_o    (new_s.res),
    .be_o     (new_s.be),
    .err_o    (new_s.err)
  );
  assign new_s.tag = i_tag_1a;

  assign acc_s   = i_vld_1a && rdy_q;
  assign drain_s = m_vld_q && i_rdy_2a;

  // Next-state of the two-entry buffer; M is always the older beat.
  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (drain_s) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        if (acc_s) begin
          s_d     = new_s;
          s_vld_d = 1'b1;
        end else begin
          s_vld_d = 1'b0;
        end
      end else if (acc_s) begin
        m_d     = new_s;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (!m_vld_q) begin
      if (acc_s) begin
        m_d     = new_s;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (acc_s) begin
      s_d     = new_s;
      s_vld_d = 1'b1;
    end else begin
      s_vld_d = s_vld_q;
    end
    rdy_d = !s_vld_d;
  end

  // Buffer state and registered ready; reset discards any buffered beats.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      rdy_q   <= rdy_d;
    end
  end

  assign o_rdy_1a = rdy_q;
  assign o_vld_2a = m_vld_q;
  assign o_res_2a = m_q.res;
  assign o_be_2a  = m_q.be;
  assign o_tag_2a = m_q.tag;
  assign o_err_2a = m_q.err;

endmodule
